// File: rtl/msg_rotator_if.sv
// Handshake and display bus between the message rotator and its controller.
// The master drives run/hold requests and slot writes; the slave returns rotation state.
interface msg_rotator_if;
   logic       start;
   logic       stop;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [2:0] wr_data;
   logic       wr_ready;
   logic       wr_err;
   logic [2:0] s;
   logic [2:0] u, v, w, x, y;
   logic       step;
   logic       running;

   modport master (
      output start, stop, wr_en, wr_addr, wr_data,
      input  wr_ready, wr_err, s, u, v, w, x, y, step, running
   );

   modport slave (
      input  start, stop, wr_en, wr_addr, wr_data,
      output wr_ready, wr_err, s, u, v, w, x, y, step, running
   );
endinterface

// File: rtl/msg_rotator.sv
// Five-character message rotator: a prescaled index s walks 0..4 while running,
// and the five character slots can be rewritten whenever rotation is idle or held.
module msg_rotator #(
   parameter int unsigned TICK_DIV = 4
) (
   input logic        clk,
   input logic        rst,
   msg_rotator_if.slave bus
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
   localparam logic [4:0][2:0] HELLO = {3'd3, 3'd2, 3'd2, 3'd1, 3'd0};

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [2:0]      s_q, s_d;
   logic            step_q, step_d;
   logic            err_q, err_d;
   logic [4:0][2:0] slot_q, slot_d;
   logic            ready;

   assign ready = (state_q != RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         presc_q <= '0;
         s_q     <= '0;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
         slot_q  <= HELLO;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         s_q     <= s_d;
         step_q  <= step_d;
         err_q   <= err_d;
         slot_q  <= slot_d;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      s_d     = s_q;
      step_d  = 1'b0;
      err_d   = 1'b0;
      slot_d  = slot_q;

      unique case (state_q)
         IDLE: begin
            presc_d = '0;
            if (bus.start && !bus.stop) state_d = RUN;
         end
         RUN: begin
            // The step is decided from the current state, so a simultaneous stop cannot cancel it.
            if (presc_q == PLAST) begin
               presc_d = '0;
               s_d     = (s_q == 3'd4) ? 3'd0 : s_q + 3'd1;
               step_d  = 1'b1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
            if (bus.stop) state_d = HOLD;
         end
         HOLD: begin
            if (bus.start && !bus.stop) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase

      if (bus.wr_en) begin
         if (ready && (bus.wr_addr <= 3'd4)) slot_d[bus.wr_addr] = bus.wr_data;
         else                                err_d = 1'b1;
      end
   end

   assign bus.s        = s_q;
   assign bus.step     = step_q;
   assign bus.running  = (state_q == RUN);
   assign bus.wr_ready = ready;
   assign bus.wr_err   = err_q;
   assign bus.u        = slot_q[0];
   assign bus.v        = slot_q[1];
   assign bus.w        = slot_q[2];
   assign bus.x        = slot_q[3];
   assign bus.y        = slot_q[4];

endmodule

// File: doc/msg_rotator.md
MSG_ROTATOR -- requirements
Module: msg_rotator

Interface
REQ-001 Parameter TICK_DIV, default 4, clk cycles per rotation step; legal range 2 to 2^24.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  level-sampled run request.
REQ-005 stop  input  1  level-sampled hold request.
REQ-006 wr_en  input  1  character write strobe.
REQ-007 wr_addr  input  3  slot index, 0..4 legal.
REQ-008 wr_data  input  3  character code.
REQ-009 wr_ready  output  1  high when writes are accepted.
REQ-010 wr_err  output  1  one-cycle pulse when a write is rejected.
REQ-011 s  output  3  rotation index to the downstream 5:1 character mux, 0..4.
REQ-012 u, v, w, x, y  output  3 each  registered character slots 0..4.
REQ-013 step  output  1  one-cycle pulse on each cycle in which s advances.
REQ-014 running  output  1  high in RUN.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and HOLD.
REQ-016 IDLE->RUN on start=1 and stop=0.
REQ-017 RUN->HOLD on stop=1.
REQ-018 HOLD->RUN on start=1 and stop=0.
REQ-019 If start and stop are both high in the same cycle, stop SHALL win: RUN goes to HOLD, IDLE and HOLD stay put.
REQ-020 HOLD SHALL never return to IDLE; only rst SHALL reach IDLE.
REQ-021 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, wrap to 0, and hold its value in HOLD.
REQ-022 The prescaler SHALL be 0 on entry to RUN from IDLE; it SHALL resume its held value on HOLD->RUN.
REQ-023 On the cycle the prescaler equals TICK_DIV-1 in RUN, s SHALL advance by 1, and step SHALL pulse high that same cycle.
REQ-024 s SHALL wrap from 4 to 0 and SHALL never take the values 5..7.
REQ-025 In IDLE and HOLD, s SHALL hold its value.
REQ-026 The first step SHALL occur TICK_DIV cycles after the RUN-entry edge.
REQ-027 A stop arriving in the same cycle as a step SHALL still let that step take effect.
REQ-028 wr_ready SHALL be 1 in IDLE and HOLD, and 0 in RUN.
REQ-029 A write SHALL be accepted only when wr_en=1, wr_ready=1 and wr_addr<=4.
REQ-030 An accepted write SHALL update the addressed slot (0=u, 1=v, 2=w, 3=x, 4=y) on the next edge.
REQ-031 A write with wr_en=1 and either wr_ready=0 or wr_addr>=5 SHALL be dropped, and wr_err SHALL be high for the following cycle.
REQ-032 A write accepted in the same cycle as a start that leaves IDLE or HOLD SHALL still take effect.
REQ-033 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-034 While rst=1, all state SHALL be forced immediately, without waiting for clk, to: state=IDLE, prescaler=0, s=0, step=0, running=0, wr_err=0, wr_ready=1.
REQ-035 While rst=1, the slots SHALL be forced to u=000, v=001, w=010, x=010, y=011, which spells HELLO.
REQ-036 rst asserted mid-RUN SHALL abort rotation with no further step pulse.
REQ-037 After rst deasserts, no state SHALL change until the first rising clk edge.

Verification (TICK_DIV=4)
REQ-038 Reset then idle 10 cycles -> s=0, u..y=0,1,2,2,3, wr_ready=1, step never high.
REQ-039 start pulse in IDLE -> running=1 next edge; step pulses every 4 cycles; s sequence 1,2,3,4,0,1; no value above 4.
REQ-040 stop for 1 cycle after s=2 with prescaler=1, wait 8 cycles, then start -> s stays 2 throughout HOLD; next step exactly 2 cycles after RUN resumes.
REQ-041 Write addr 4 data 111 in HOLD -> y=111 next edge, no wr_err; same write in RUN -> y unchanged and wr_err=1 for one cycle; addr 6 in IDLE -> wr_err=1, slots unchanged.
REQ-042 start and stop together in IDLE -> stays IDLE; together in RUN -> HOLD.
REQ-043 rst asserted mid-cycle while running with s=3 -> s=0, running=0 and slots at HELLO before the next clk edge.
